// File: rtl/ledger_cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ledger_cmd_rx                                                 |
// | Purpose  : Serial command receiver/executor for the key/value balance    |
// |            ledger. Deserialises a tick-paced bit stream into bytes,      |
// |            assembles ISSUE/TRANSFER/REFER frames and executes them       |
// |            against an internal balance table.                            |
// | Ports    : clock, reset_n (async, active low)                            |
// |            tick      - baud square wave, asynchronous to clock           |
// |            rx_serial - command line, idles high                          |
// |            value_out / value_valid - result of last good command         |
// |            cmd_error - one-clock pulse per rejected frame                |
// |            busy      - table clear or command execution in progress      |
// |            tx_serial - response line (RESP_TX_EN), else constant 1       |
// | Options  : `define RESP_TX_EN to enable the response transmitter.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ledger_cmd_rx #(
    parameter int ADDR_W = 10,
    parameter int VAL_W  = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             rx_serial,
    output logic [VAL_W-1:0] value_out,
    output logic             value_valid,
    output logic             cmd_error,
    output logic             busy,
    output logic             tx_serial
);
    localparam int                c_depth     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    // Control FSM
    localparam logic [2:0] c_st_clear = 3'd0, c_st_idle = 3'd1, c_st_ex_a = 3'd2,
                           c_st_ex_b  = 3'd3, c_st_ex_sat = 3'd4;
    // Byte receiver FSM
    localparam logic [1:0] c_rx_idle = 2'd0, c_rx_data = 2'd1, c_rx_stop = 2'd2;
    // Frame assembler FSM
    localparam logic [1:0] c_asm_op = 2'd0, c_asm_field = 2'd1, c_asm_term = 2'd2,
                           c_asm_discard = 2'd3;
    // Opcode low bits retained after decode
    localparam logic [1:0] c_op_issue = 2'b00, c_op_xfer = 2'b10, c_op_refer = 2'b11;

    // ---------------- synchronisers ----------------
    logic [2:0] r_tick_sync;    // [0] meta, [1] synced, [2] previous synced
    logic [1:0] r_rx_sync;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_sync <= 3'b000;
            r_rx_sync   <= 2'b11;
        end else begin
            r_tick_sync <= {r_tick_sync[1:0], tick};
            r_rx_sync   <= {r_rx_sync[0], rx_serial};
        end
    end
    logic w_tick_pulse, w_rx;
    assign w_tick_pulse = r_tick_sync[1] & ~r_tick_sync[2];
    assign w_rx         = r_rx_sync[1];

    logic [2:0] r_state, w_state_nxt;
    logic       w_clearing;
    assign w_clearing = (r_state == c_st_clear);

    // ---------------- byte receiver ----------------
    logic [1:0] r_rx_state, w_rx_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       w_byte_strobe, w_frame_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rx_state <= c_rx_idle;
        else          r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        if (w_clearing) begin
            w_rx_state_nxt = c_rx_idle;
        end else if (w_tick_pulse) begin
            case (r_rx_state)
                c_rx_idle: if (!w_rx) w_rx_state_nxt = c_rx_data;
                c_rx_data: if (r_bit_cnt == 3'd7) w_rx_state_nxt = c_rx_stop;
                default:   w_rx_state_nxt = c_rx_idle;
            endcase
        end
    end

    always_comb begin
        w_byte_strobe = w_tick_pulse && (r_rx_state == c_rx_stop) &&  w_rx;
        w_frame_err   = w_tick_pulse && (r_rx_state == c_rx_stop) && !w_rx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (w_tick_pulse) begin
            if (r_rx_state == c_rx_idle) begin
                r_bit_cnt <= 3'd0;
            end else if (r_rx_state == c_rx_data) begin
                r_shift   <= {w_rx, r_shift[7:1]};   // LSB arrives first
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // ---------------- frame assembler ----------------
    logic [1:0]         r_asm_state;
    logic [1:0]         r_op;
    logic [3:0]         r_cnt, r_need;
    logic [3*VAL_W-1:0] r_fields;    // field bytes shifted in big-endian
    logic               w_op_known, w_asm_err, w_exec_go;

    assign w_op_known = (r_shift == 8'h00) || (r_shift == 8'h02) || (r_shift == 8'h03);
    assign w_asm_err  = w_byte_strobe &&
                        (((r_asm_state == c_asm_op)   && !w_op_known) ||
                         ((r_asm_state == c_asm_term) && (r_shift != 8'h00)));
    assign w_exec_go  = w_byte_strobe && (r_asm_state == c_asm_term) && (r_shift == 8'h00);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_asm_state <= c_asm_op;
            r_op        <= 2'd0;
            r_cnt       <= 4'd0;
            r_need      <= 4'd0;
            r_fields    <= '0;
        end else if (w_clearing || w_frame_err) begin
            r_asm_state <= c_asm_op;
        end else if (w_byte_strobe) begin
            case (r_asm_state)
                c_asm_op: begin
                    r_fields <= '0;
                    r_cnt    <= 4'd0;
                    r_op     <= r_shift[1:0];
                    case (r_shift)
                        8'h00:   begin r_need <= 4'd8;  r_asm_state <= c_asm_field; end
                        8'h02:   begin r_need <= 4'd12; r_asm_state <= c_asm_field; end
                        8'h03:   begin r_need <= 4'd4;  r_asm_state <= c_asm_field; end
                        default: r_asm_state <= c_asm_discard;
                    endcase
                end
                c_asm_field: begin
                    r_fields <= {r_fields[3*VAL_W-9:0], r_shift};
                    r_cnt    <= r_cnt + 4'd1;
                    if (r_cnt == r_need - 4'd1) r_asm_state <= c_asm_term;
                end
                c_asm_discard: if (r_shift == 8'h00) r_asm_state <= c_asm_op;
                default:       r_asm_state <= c_asm_op;
            endcase
        end
    end

    // Field positions depend on the opcode: REFER keeps its key in the low word.
    logic [VAL_W-1:0] w_key_a, w_key_b, w_amt;
    logic             w_bad_key;
    assign w_key_a   = (r_op == c_op_issue) ? r_fields[2*VAL_W-1:VAL_W] :
                       (r_op == c_op_xfer)  ? r_fields[3*VAL_W-1:2*VAL_W] :
                                              r_fields[VAL_W-1:0];
    assign w_key_b   = r_fields[2*VAL_W-1:VAL_W];
    assign w_amt     = r_fields[VAL_W-1:0];
    assign w_bad_key = (|w_key_a[VAL_W-1:ADDR_W]) ||
                       ((r_op == c_op_xfer) && (|w_key_b[VAL_W-1:ADDR_W]));

    // ---------------- balance table ----------------
    logic [VAL_W-1:0]  r_mem [c_depth];
    logic [ADDR_W-1:0] r_clr_addr, w_rd_addr, w_mem_waddr;
    logic [VAL_W-1:0]  w_rd_data, w_mem_wdata, w_diff, w_sum_sat, w_new_val, r_from_new;
    logic [VAL_W:0]    w_sum;
    logic              w_mem_we, w_set_valid, w_exec_err;

    assign w_rd_addr = (r_state == c_st_ex_b) ? w_key_b[ADDR_W-1:0] : w_key_a[ADDR_W-1:0];
    assign w_rd_data = r_mem[w_rd_addr];
    assign w_sum     = {1'b0, w_rd_data} + {1'b0, w_amt};
    assign w_sum_sat = w_sum[VAL_W] ? {VAL_W{1'b1}} : w_sum[VAL_W-1:0];
    assign w_diff    = w_rd_data - w_amt;

    always_ff @(posedge clock) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= c_st_clear;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_clear: if (r_clr_addr == c_last_addr) w_state_nxt = c_st_idle;
            c_st_idle:  if (w_exec_go) w_state_nxt = c_st_ex_a;
            c_st_ex_a: begin
                w_state_nxt = c_st_idle;
                if (!w_bad_key && (r_op == c_op_xfer) && (w_rd_data >= w_amt))
                    w_state_nxt = c_st_ex_b;
                else if (!w_bad_key && (r_op == c_op_issue) && w_sum[VAL_W])
                    w_state_nxt = c_st_ex_sat;   // error pulse one clock after the valid
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_clr_addr;
        w_mem_wdata = '0;
        w_set_valid = 1'b0;
        w_new_val   = value_out;
        w_exec_err  = 1'b0;
        case (r_state)
            c_st_clear: w_mem_we = 1'b1;
            c_st_ex_a: begin
                if (w_bad_key) begin
                    w_exec_err = 1'b1;
                end else if (r_op == c_op_issue) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = w_key_a[ADDR_W-1:0];
                    w_mem_wdata = w_sum_sat;
                    w_set_valid = 1'b1;
                    w_new_val   = w_sum_sat;
                end else if (r_op == c_op_xfer) begin
                    if (w_rd_data < w_amt) begin
                        w_exec_err = 1'b1;
                    end else begin
                        w_mem_we    = 1'b1;
                        w_mem_waddr = w_key_a[ADDR_W-1:0];
                        w_mem_wdata = w_diff;
                    end
                end else if (r_op == c_op_refer) begin
                    w_set_valid = 1'b1;
                    w_new_val   = w_rd_data;
                end
            end
            c_st_ex_b: begin
                // With FROM == TO the debit is re-credited here, restoring the original.
                w_mem_we    = 1'b1;
                w_mem_waddr = w_key_b[ADDR_W-1:0];
                w_mem_wdata = w_sum_sat;
                w_set_valid = 1'b1;
                w_new_val   = (w_key_a == w_key_b) ? w_sum_sat : r_from_new;
            end
            c_st_ex_sat: w_exec_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_out   <= '0;
            value_valid <= 1'b0;
            cmd_error   <= 1'b0;
            r_clr_addr  <= '0;
            r_from_new  <= '0;
        end else begin
            value_valid <= w_set_valid;
            cmd_error   <= w_exec_err | w_asm_err | w_frame_err;
            if (w_set_valid) value_out <= w_new_val;
            if (w_clearing) r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (r_state == c_st_ex_a) r_from_new <= w_diff;
        end
    end

    assign busy = (r_state != c_st_idle);

    // ---------------- optional response transmitter ----------------
`ifdef RESP_TX_EN
    logic [39:0]      r_tx_sr;
    logic [5:0]       r_tx_cnt;
    logic             r_tx_busy, r_pend_valid, r_tx_line;
    logic [VAL_W-1:0] r_pend_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_sr      <= '1;
            r_tx_cnt     <= 6'd0;
            r_tx_busy    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_tx_line    <= 1'b1;
        end else begin
            // One-deep pending slot; a newer result overwrites an unsent one.
            if (value_valid) begin
                r_pend_data  <= value_out;
                r_pend_valid <= 1'b1;
            end else if (!r_tx_busy && r_pend_valid) begin
                r_pend_valid <= 1'b0;
            end
            if (!r_tx_busy) begin
                if (r_pend_valid) begin
                    // Four 10-bit characters, MSB byte in the lowest (first-sent) slot.
                    r_tx_sr   <= {1'b1, r_pend_data[7:0],   1'b0,
                                  1'b1, r_pend_data[15:8],  1'b0,
                                  1'b1, r_pend_data[23:16], 1'b0,
                                  1'b1, r_pend_data[31:24], 1'b0};
                    r_tx_cnt  <= 6'd0;
                    r_tx_busy <= 1'b1;
                end
            end else if (w_tick_pulse) begin
                if (r_tx_cnt == 6'd40) begin
                    r_tx_line <= 1'b1;
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_line <= r_tx_sr[0];
                    r_tx_sr   <= {1'b1, r_tx_sr[39:1]};
                    r_tx_cnt  <= r_tx_cnt + 6'd1;
                end
            end
        end
    end
    assign tx_serial = r_tx_line;
`else
    assign tx_serial = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ledger_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ledger_cmd_rx                                              |
// | Purpose  : Self-checking bench for ledger_cmd_rx. Serialises command     |
// |            frames on rx_serial and compares results, error pulses and    |
// |            result latency against a frame-level balance model.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ledger_cmd_rx;
    localparam int c_depth = 1024;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        tick      = 1'b0;
    logic        rx_serial = 1'b1;
    logic [31:0] value_out;
    logic        value_valid, cmd_error, busy, tx_serial;

    ledger_cmd_rx #(.ADDR_W(10), .VAL_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .rx_serial  (rx_serial),
        .value_out  (value_out),
        .value_valid(value_valid),
        .cmd_error  (cmd_error),
        .busy       (busy),
        .tx_serial  (tx_serial)
    );

    always #5  clock = ~clock;
    always #43 tick  = ~tick;     // unrelated to the clock period

    typedef logic [7:0] bq_t[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // ---------------- output monitor ----------------
    int mon_valid = 0, mon_err = 0, mon_both = 0, mon_lat = -1, since_strobe = 0;
    always @(negedge clock) begin
        if (dut.w_byte_strobe) since_strobe = 0;
        else                   since_strobe++;
        if (value_valid) begin mon_valid++; mon_lat = since_strobe; end
        if (cmd_error) mon_err++;
        if (value_valid && cmd_error) mon_both++;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_bal [c_depth];
    logic [31:0] m_value;

    function automatic void model_reset();
        foreach (m_bal[i]) m_bal[i] = 32'd0;
        m_value = 32'd0;
    endfunction

    function automatic logic [31:0] get32(input bq_t q, input int i);
        return {q[i], q[i+1], q[i+2], q[i+3]};
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        s = a;
        s += b;
        return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Applies one whole frame to the model; ev/ee are expected valid/error pulse counts.
    function automatic void model_frame(input bq_t q, output int ev, output int ee, output int lat);
        logic [31:0] k1, k2, amt;
        longint unsigned s;
        ev = 0; ee = 0; lat = 0;
        case (q[0])
            8'h00: begin
                k1 = get32(q, 1); amt = get32(q, 5);
                if (q[9] != 8'h00 || k1 >= 32'(c_depth)) ee = 1;
                else begin
                    s = m_bal[k1];
                    s += amt;
                    if (s > 64'h0000_0000_FFFF_FFFF) ee = 1;
                    m_bal[k1] = sat_add(m_bal[k1], amt);
                    m_value = m_bal[k1]; ev = 1; lat = 2;
                end
            end
            8'h02: begin
                k1 = get32(q, 1); k2 = get32(q, 5); amt = get32(q, 9);
                if (q[13] != 8'h00 || k1 >= 32'(c_depth) || k2 >= 32'(c_depth)) ee = 1;
                else if (m_bal[k1] < amt) ee = 1;
                else begin
                    m_bal[k1] = m_bal[k1] - amt;
                    m_bal[k2] = sat_add(m_bal[k2], amt);
                    m_value = m_bal[k1]; ev = 1; lat = 3;
                end
            end
            8'h03: begin
                k1 = get32(q, 1);
                if (q[5] != 8'h00 || k1 >= 32'(c_depth)) ee = 1;
                else begin m_value = m_bal[k1]; ev = 1; lat = 2; end
            end
            default: ee = 1;   // unknown opcode; frame body runs to its 0x00
        endcase
    endfunction

    // ---------------- frame builders ----------------
    function automatic bq_t put32(input bq_t q, input logic [31:0] v);
        bq_t r;
        r = q;
        r.push_back(v[31:24]); r.push_back(v[23:16]); r.push_back(v[15:8]); r.push_back(v[7:0]);
        return r;
    endfunction
    function automatic bq_t f_issue(input logic [31:0] key, input logic [31:0] amt, input logic [7:0] term);
        bq_t q;
        q.push_back(8'h00); q = put32(q, key); q = put32(q, amt); q.push_back(term);
        return q;
    endfunction
    function automatic bq_t f_xfer(input logic [31:0] from, input logic [31:0] to,
                                   input logic [31:0] amt, input logic [7:0] term);
        bq_t q;
        q.push_back(8'h02); q = put32(q, from); q = put32(q, to); q = put32(q, amt); q.push_back(term);
        return q;
    endfunction
    function automatic bq_t f_refer(input logic [31:0] key, input logic [7:0] term);
        bq_t q;
        q.push_back(8'h03); q = put32(q, key); q.push_back(term);
        return q;
    endfunction

    // ---------------- serial driver ----------------
    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(negedge tick); rx_serial = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge tick); rx_serial = b[i];
        end
        @(negedge tick); rx_serial = good_stop;
        if (!good_stop) begin
            @(negedge tick); rx_serial = 1'b1;
        end
    endtask

    task automatic clear_monitor();
        @(posedge clock);
        mon_valid = 0; mon_err = 0; mon_lat = -1;
    endtask

    task automatic settle();
        @(negedge tick);
        repeat (12) @(posedge clock);
        #1;
    endtask

    task automatic exec_frame(input string tag, input bq_t q);
        int ev, ee, lat;
        model_frame(q, ev, ee, lat);
        clear_monitor();
        foreach (q[i]) send_byte(q[i], 1'b1);
        settle();
        check_eq($sformatf("%s valid_count", tag), mon_valid, ev);
        check_eq($sformatf("%s error_count", tag), mon_err, ee);
        check_eq($sformatf("%s value_out", tag), value_out, m_value);
        if (ev != 0) check_eq($sformatf("%s latency", tag), mon_lat, lat);
    endtask

    task automatic release_and_clear(input string tag);
        int n;
        n = 0;
        @(negedge clock); reset_n = 1'b1;
        do begin
            @(posedge clock); #1; n++;
        end while (busy && n < 3000);
        check_eq(tag, n, 1024);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq($sformatf("%s value_out", tag), value_out, 32'd0);
        check_eq($sformatf("%s value_valid", tag), value_valid, 32'd0);
        check_eq($sformatf("%s cmd_error", tag), cmd_error, 32'd0);
        check_eq($sformatf("%s busy", tag), busy, 32'd1);
        check_eq($sformatf("%s tx_serial", tag), tx_serial, 32'd1);
    endtask

    // ---------------- random field generators ----------------
    function automatic logic [31:0] rand_key();
        logic [31:0] pool [6];
        int r;
        pool = '{32'd19, 32'd524, 32'd279, 32'd1023, 32'd0, 32'd7};
        r = $urandom_range(0, 19);
        if (r == 0) return 32'd1024;
        if (r == 1) return $urandom() | 32'h0000_0400;
        return pool[r % 6];
    endfunction

    function automatic logic [31:0] rand_amt();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'd0;
        if (r == 1) return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        return 32'($urandom_range(1, 200));
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        bq_t q;
        int  r;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        release_and_clear("reset busy_clocks");

        exec_frame("refer279", f_refer(32'd279, 8'h00));
        exec_frame("issue524", f_issue(32'd524, 32'd100, 8'h00));
        exec_frame("xfer524_19", f_xfer(32'd524, 32'd19, 32'd40, 8'h00));
        exec_frame("refer19", f_refer(32'd19, 8'h00));
        exec_frame("xfer_insuf", f_xfer(32'd279, 32'd19, 32'd100, 8'h00));
        exec_frame("refer19_again", f_refer(32'd19, 8'h00));
        exec_frame("issue_badterm", f_issue(32'd524, 32'd5, 8'h05));
        exec_frame("refer524", f_refer(32'd524, 8'h00));

        // Stop bit forced low in the middle of an ISSUE frame.
        clear_monitor();
        q = f_issue(32'd524, 32'd9, 8'h00);
        for (int i = 0; i < 4; i++) send_byte(q[i], 1'b1);
        send_byte(q[4], 1'b0);
        settle();
        check_eq("framing valid_count", mon_valid, 32'd0);
        check_eq("framing error_count", mon_err, 32'd1);
        exec_frame("refer524_after_framing", f_refer(32'd524, 8'h00));

        q = '{8'h07, 8'h00};
        exec_frame("unknown_op", q);
        exec_frame("refer19_after_unknown", f_refer(32'd19, 8'h00));

        exec_frame("xfer_self", f_xfer(32'd19, 32'd19, 32'd10, 8'h00));
        exec_frame("xfer_amt0", f_xfer(32'd279, 32'd19, 32'd0, 8'h00));
        exec_frame("issue_key_oob", f_issue(32'd1024, 32'd1, 8'h00));
        exec_frame("issue1023", f_issue(32'd1023, 32'hFFFF_FFF0, 8'h00));
        exec_frame("issue1023_sat", f_issue(32'd1023, 32'h0000_0020, 8'h00));
        exec_frame("xfer_to_sat", f_xfer(32'd524, 32'd1023, 32'd7, 8'h00));

        for (int n = 0; n < 20; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      q = f_issue(rand_key(), rand_amt(), 8'h00);
            else if (r < 7) q = f_xfer(rand_key(), rand_key(), rand_amt(), 8'h00);
            else if (r < 9) q = f_refer(rand_key(), 8'h00);
            else            q = f_refer(rand_key(), 8'($urandom_range(1, 255)));
            exec_frame($sformatf("rand%0d", n), q);
        end

        // Reset pulsed in the middle of a TRANSFER frame.
        q = f_xfer(32'd524, 32'd19, 32'd1, 8'h00);
        for (int i = 0; i < 5; i++) send_byte(q[i], 1'b1);
        #7 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clock);
        model_reset();
        release_and_clear("midreset busy_clocks");
        exec_frame("post_reset_refer524", f_refer(32'd524, 8'h00));
        exec_frame("post_reset_refer19", f_refer(32'd19, 8'h00));
        exec_frame("post_reset_refer1023", f_refer(32'd1023, 8'h00));

        check_eq("valid_and_error_same_cycle", mon_both, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ledger_cmd_rx.md
Name: ledger_cmd_rx

Overview:
- Serial command receiver and executor for the key/value balance ledger.
- Deserialises a tick-paced asynchronous bit stream into bytes and assembles them into ISSUE / TRANSFER / REFER command frames.
- Executes each frame against an internal balance table and presents the resulting balance on value_out.
- Sits between the host serial link and downstream ledger logic.

Parameters:
- ADDR_W, 10, key index width; table depth = 2^ADDR_W entries.
- VAL_W, 32, balance and amount width. Fixed at 32; frame fields are 4 bytes.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  baud square wave; each rising edge is one bit period. Asynchronous to clock.
- rx_serial  in  1  serial command line; idles high.
- value_out  out  32  balance produced by the last successful command.
- value_valid  out  1  one-clock pulse when value_out updates.
- cmd_error  out  1  one-clock pulse on any rejected frame.
- busy  out  1  high during table clear or command execution.
- tx_serial  out  1  response line; only functional with RESP_TX_EN, otherwise tied high.

Behaviour:
- Reset (async, reset_n=0):
  - value_out=0, value_valid=0, cmd_error=0, tx_serial=1, busy=1.
  - All FSMs go idle.
  - On release, CLEAR state zeroes one table entry per clock for 2^ADDR_W clocks, then busy=0.
  - rx_serial is ignored during CLEAR.
- Tick and rx handling:
  - tick passes through a 2-flop synchroniser; a rising edge of the synchronised tick gives a one-clock tick_pulse.
  - rx_serial is also 2-flop synchronised.
- Byte receiver (all decisions on tick_pulse):
  - IDLE: rx=0 → DATA.
  - DATA: 8 samples, LSB first.
  - STOP: rx=1 → byte accepted (one-clock byte_strobe). rx=0 → framing error: cmd_error pulse, current frame aborted, back to IDLE.
- Frame format (bytes in order; multi-byte fields big-endian):
  - ISSUE: op=0x00, KEY[4], AMT[4], TERM=0x00 (10 bytes).
  - TRANSFER: op=0x02, FROM[4], TO[4], AMT[4], TERM=0x00 (14 bytes).
  - REFER: op=0x03, KEY[4], TERM=0x00 (6 bytes).
- Frame errors:
  - Unknown opcode: cmd_error pulse; discard bytes until a 0x00 byte, then expect a new opcode.
  - TERM ≠ 0x00: cmd_error pulse; frame discarded; no table change.
  - Any key ≥ 2^ADDR_W: cmd_error pulse at execution; no table change.
- Execution starts the clock after the TERM byte_strobe. busy is high throughout; bytes arriving during execution are still received.
- ISSUE:
  - new = bal[KEY] + AMT, saturating at 0xFFFFFFFF.
  - On saturation, cmd_error pulses as well, but the saturated value is still written.
  - value_out = new. value_valid asserts 2 clocks after TERM accept.
- TRANSFER:
  - If bal[FROM] ≥ AMT: bal[FROM] −= AMT, then bal[TO] += AMT (saturating). value_out = new bal[FROM]. value_valid asserts 3 clocks after TERM accept.
  - If bal[FROM] < AMT: cmd_error pulse, no change, no value_valid.
  - FROM == TO: no change; value_out = bal[FROM], valid if sufficient.
  - AMT = 0 is legal.
- REFER: value_out = bal[KEY]; value_valid asserts 2 clocks after TERM accept.
- value_valid and cmd_error never pulse in the same cycle.
- value_out holds its value between updates.
- reset_n asserted mid-frame or mid-execution: partial frame discarded; table cleared again after release.

Optional Feature:
- RESP_TX_EN defined:
  - After each value_valid, transmit value_out as 4 bytes, MSB first.
  - Per byte: start bit 0, 8 data bits LSB first, stop bit 1; one bit per tick_pulse; tx_serial idles high.
  - If a new value_valid arrives while sending, the new result is queued; depth 1, newest overwrites.
- RESP_TX_EN undefined: no transmit logic; tx_serial is constant 1.

Test Plan:
- After reset, wait for busy=0, then REFER key 279 (bytes 03 00 00 01 17 00) → value_out=0, value_valid pulse, no cmd_error.
- ISSUE key 524 amount 100 (00 00 00 02 0C 00 00 00 64 00) → value_out=100 exactly 2 clocks after TERM accept.
- Then TRANSFER 524→19 amount 40 → value_out=60. Then REFER 19 → 40.
- TRANSFER 279→19 amount 100 with bal[279]=0 → cmd_error pulse, no value_valid; a following REFER 19 still returns 40.
- ISSUE frame with TERM=0x05 → cmd_error; REFER 524 returns unchanged 60.
- Stop-bit forced to 0 mid-frame → cmd_error, frame dropped.
- Unknown opcode 0x07 followed by a valid REFER → one cmd_error, then correct REFER result.
- reset_n pulsed mid-TRANSFER → outputs return to 0, busy=1 for 1024 clocks, all balances read back 0.
